// File: rtl/restoring_divider_pkg.sv
// -----------------------------------------------------------------------------
// restoring_divider_pkg
//   Shared definitions for the sequential restoring divider:
//     SIZE_DATA   default operand / result width
//     divState_e  controller state encoding (IDLE, LOAD, RUN, DONE)
//     countWidth  width of the iteration counter for a given operand width
// -----------------------------------------------------------------------------
package restoring_divider_pkg;

  localparam int SIZE_DATA = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } divState_e;

  // One extra bit so the counter can hold the value SIZE itself.
  function automatic int countWidth(input int size);
    return $clog2(size) + 1;
  endfunction

endpackage

// File: rtl/restoring_divider_ctrl.sv
// -----------------------------------------------------------------------------
// divider_ctrl
//   FSM and iteration counter for the restoring divider.
//   Ports:
//     clk, reset   rising-edge clock, synchronous active-high reset
//     start        request, honoured only in IDLE
//     skipRun      divisor-zero shortcut request, sampled in LOAD
//     trialSign    sign bit of the current trial subtraction
//     load         capture operands (IDLE with start)
//     shift        perform one shift/subtract iteration (RUN)
//     takeTrial    keep the trial difference and set the quotient bit
//     finish       last RUN iteration: capture final Q/R into result registers
//     skip         LOAD shortcut to DONE: capture divide-by-zero result
//     busy, done   status outputs (LOAD/RUN, DONE)
// -----------------------------------------------------------------------------
module divider_ctrl
  import restoring_divider_pkg::*;
#(
  parameter int SIZE = SIZE_DATA
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic skipRun,
  input  logic trialSign,
  output logic load,
  output logic shift,
  output logic takeTrial,
  output logic finish,
  output logic skip,
  output logic busy,
  output logic done
);

  localparam int CW = countWidth(SIZE);

  divState_e     stateReg, stateNext;
  logic [CW-1:0] countReg, countNext;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
      countReg <= '0;
    end else begin
      stateReg <= stateNext;
      countReg <= countNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    countNext = countReg;
    load      = 1'b0;
    shift     = 1'b0;
    finish    = 1'b0;
    skip      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          countNext = CW'(SIZE);
          stateNext = LOAD;
        end
      end
      LOAD: begin
        if (skipRun) begin
          skip      = 1'b1;
          stateNext = DONE;
        end else begin
          stateNext = RUN;
        end
      end
      RUN: begin
        shift     = 1'b1;
        countNext = countReg - 1'b1;
        if (countReg == CW'(1)) begin
          finish    = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // A non-negative trial means the divisor fits: accept it.
  assign takeTrial = shift & ~trialSign;
  assign busy      = (stateReg == LOAD) || (stateReg == RUN);
  assign done      = (stateReg == DONE);

endmodule

// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider
//   Sequential unsigned restoring divider, one quotient bit per clock.
//   Latency start -> done is SIZE+2 cycles; results are registered and hold
//   until the next completed operation or reset.
//   Optional feature macro: DIV_ZERO_DETECT_EN (divisor 0 short-circuits to
//   DONE after LOAD and raises div_by_zero; otherwise div_by_zero is 0).
//   Ports:
//     clk, reset            rising-edge clock, synchronous active-high reset
//     start                 request, sampled only when idle
//     dividend, divisor     operands, captured on an accepted start
//     busy                  high while loading / iterating
//     done                  one-cycle strobe, results valid from this cycle
//     quotient, remainder   registered results
//     div_by_zero           registered divide-by-zero flag
//   Requires SIZE >= 2.
// -----------------------------------------------------------------------------
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int SIZE = SIZE_DATA
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder,
  output logic            div_by_zero
);

  // The partial remainder is held at SIZE bits: after every restore step it
  // is strictly below D, so only the shifted value needs the extra bit.
  logic [SIZE-1:0] rReg, qReg, dReg;
  logic [SIZE:0]   rShift, trial;
  logic [SIZE-1:0] rStep, qStep;
  logic [SIZE-1:0] quotientReg, remainderReg;
  logic            load, shift, takeTrial, finish, skip, skipRun;

  assign rShift = {rReg, qReg[SIZE-1]};
  assign trial  = rShift - {1'b0, dReg};
  assign rStep  = takeTrial ? trial[SIZE-1:0] : rShift[SIZE-1:0];
  assign qStep  = {qReg[SIZE-2:0], takeTrial};

`ifdef DIV_ZERO_DETECT_EN
  assign skipRun = (dReg == '0);
`else
  assign skipRun = 1'b0;
`endif

  divider_ctrl #(.SIZE(SIZE)) ctrl (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .skipRun   (skipRun),
    .trialSign (trial[SIZE]),
    .load      (load),
    .shift     (shift),
    .takeTrial (takeTrial),
    .finish    (finish),
    .skip      (skip),
    .busy      (busy),
    .done      (done)
  );

  // Working registers: R, Q, D.
  always_ff @(posedge clk) begin
    if (reset) begin
      rReg <= '0;
      qReg <= '0;
      dReg <= '0;
    end else if (load) begin
      rReg <= '0;
      qReg <= dividend;
      dReg <= divisor;
    end else if (shift) begin
      rReg <= rStep;
      qReg <= qStep;
    end
  end

  // Result registers capture the final iteration's next values directly, so
  // they are already valid in the DONE cycle and partial values never leak.
  always_ff @(posedge clk) begin
    if (reset) begin
      quotientReg  <= '0;
      remainderReg <= '0;
    end else if (finish) begin
      quotientReg  <= qStep;
      remainderReg <= rStep;
    end else if (skip) begin
      quotientReg  <= '1;
      remainderReg <= qReg;
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic divByZeroReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      divByZeroReg <= 1'b0;
    end else if (finish) begin
      divByZeroReg <= 1'b0;
    end else if (skip) begin
      divByZeroReg <= 1'b1;
    end
  end

  assign div_by_zero = divByZeroReg;
`else
  assign div_by_zero = 1'b0;
`endif

  assign quotient  = quotientReg;
  assign remainder = remainderReg;

endmodule
